// File: rtl/pipe_addsub.sv
// Pipelined two's-complement adder/subtractor.
// The WIDTH-bit carry chain is cut into STAGES registered chunks of CHUNK bits.
// Each stage sums one chunk and forwards the completed low part of S, its chunk
// carry, and the untouched upper operand bits. A valid/ready handshake with
// bubble collapsing gives one result per cycle.
module pipe_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic             carryin,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             carryout,
  output logic             overflow
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  // Reject illegal geometry at elaboration time.
  generate
    if ((WIDTH < 2) || (STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
      $error("pipe_addsub: WIDTH must be >= 2 and a multiple of STAGES (1..WIDTH)");
    end
  endgenerate

  // Bit-level ripple over one chunk, exactly as chained full adders.
  // Returns {carry into chunk MSB, chunk carry-out, chunk sum}.
  function automatic logic [CHUNK+1:0] chunk_add(
    input logic [CHUNK-1:0] a,
    input logic [CHUNK-1:0] b,
    input logic             ci
  );
    logic [CHUNK:0]   c;
    logic [CHUNK-1:0] s;
    c[0] = ci;
    for (int j = 0; j < CHUNK; j++) begin
      s[j]   = a[j] ^ b[j] ^ c[j];
      c[j+1] = (a[j] & b[j]) | (c[j] & (a[j] ^ b[j]));
    end
    return {c[CHUNK-1], c[CHUNK], s};
  endfunction

  // Pipeline state, one entry per stage.
  logic [STAGES-1:0] v_r;
  logic [STAGES-1:0] c_r;
  logic [WIDTH-1:0]  s_r [STAGES];
  logic [WIDTH-1:0]  x_r [STAGES];
  logic [WIDTH-1:0]  y_r [STAGES];
  logic              ov_r;

  // Stage inputs (from the ports for stage 0, from the previous register otherwise).
  logic [WIDTH-1:0]  xin_s   [STAGES];
  logic [WIDTH-1:0]  yin_s   [STAGES];
  logic [WIDTH-1:0]  sin_s   [STAGES];
  logic [WIDTH-1:0]  snext_s [STAGES];
  logic [STAGES-1:0] cin_s;
  logic [STAGES-1:0] vin_s;
  logic [STAGES-1:0] cnext_s;
  logic [STAGES-1:0] adv_s;
  logic              cmsb_s;
  logic [WIDTH-1:0]  yeff_s;
  logic              c0_s;

  // Operand conditioning: subtraction is X + ~Y + 1, carryin ignored.
  always_comb begin
    yeff_s = Y;
    c0_s   = carryin;
    if (sub) begin
      yeff_s = ~Y;
      c0_s   = 1'b1;
    end else begin
      yeff_s = Y;
      c0_s   = carryin;
    end
  end

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage_in
      if (k == 0) begin : g_first
        assign xin_s[k] = X;
        assign yin_s[k] = yeff_s;
        assign sin_s[k] = {WIDTH{1'b0}};
        assign cin_s[k] = c0_s;
        assign vin_s[k] = in_valid & in_ready;
      end else begin : g_rest
        assign xin_s[k] = x_r[k-1];
        assign yin_s[k] = y_r[k-1];
        assign sin_s[k] = s_r[k-1];
        assign cin_s[k] = c_r[k-1];
        assign vin_s[k] = v_r[k-1];
      end
    end
  endgenerate

  // Per-stage chunk arithmetic; the last stage also exposes the carry into the MSB.
  always_comb begin
    logic [CHUNK+1:0] r;
    r       = {(CHUNK+2){1'b0}};
    cnext_s = {STAGES{1'b0}};
    cmsb_s  = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      r = chunk_add(xin_s[k][k*CHUNK +: CHUNK], yin_s[k][k*CHUNK +: CHUNK], cin_s[k]);
      snext_s[k] = sin_s[k];
      snext_s[k][k*CHUNK +: CHUNK] = r[CHUNK-1:0];
      cnext_s[k] = r[CHUNK];
      if (k == LAST) begin
        cmsb_s = r[CHUNK+1];
      end else begin
        cmsb_s = cmsb_s;
      end
    end
  end

  // Stage k may advance when the output is taken or any stage from k onward is empty.
  always_comb begin
    logic any_empty;
    any_empty = 1'b0;
    adv_s     = {STAGES{1'b0}};
    for (int k = 0; k < STAGES; k++) begin
      any_empty = 1'b0;
      for (int j = k; j < STAGES; j++) begin
        any_empty = any_empty | ~v_r[j];
      end
      adv_s[k] = out_ready | any_empty;
    end
  end

  assign in_ready = adv_s[0] & ~reset;

  // Pipeline registers: shift on advance, load data only when a valid op arrives.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v_r  <= {STAGES{1'b0}};
      c_r  <= {STAGES{1'b0}};
      ov_r <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        s_r[k] <= {WIDTH{1'b0}};
        x_r[k] <= {WIDTH{1'b0}};
        y_r[k] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv_s[k]) begin
          v_r[k] <= vin_s[k];
          if (vin_s[k]) begin
            s_r[k] <= snext_s[k];
            c_r[k] <= cnext_s[k];
            x_r[k] <= xin_s[k];
            y_r[k] <= yin_s[k];
          end
        end
      end
      if (adv_s[LAST] && vin_s[LAST]) begin
        ov_r <= cmsb_s ^ cnext_s[LAST];
      end
    end
  end

  assign out_valid = v_r[LAST];
  assign S         = s_r[LAST];
  assign carryout  = c_r[LAST];
  assign overflow  = ov_r;

endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub: a 4-stage instance exercised by all
// directed steps, plus 1-stage and 16-stage instances fed the random burst.
module tb_pipe_addsub;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, sub, carryin, out_ready, use_b;
  logic [15:0] X, Y;

  logic        in_ready, out_valid, carryout, overflow;
  logic [15:0] S;
  logic        b_in_valid;
  logic        s1_in_ready, s1_out_valid, s1_carryout, s1_overflow;
  logic [15:0] s1_S;
  logic        s16_in_ready, s16_out_valid, s16_carryout, s16_overflow;
  logic [15:0] s16_S;

  int          total = 0;
  int          passed = 0;
  int          cyc = 0;
  int          pop_cyc0, acc_cyc0, full_seen, tpat, c_start;
  logic        accepted0, tmode;
  logic [17:0] cur_exp;
  logic [17:0] q [3][$];
  logic        prev_stall [3];
  logic [17:0] held [3];
  int          stg [3];

  always #5 clock = ~clock;

  assign b_in_valid = in_valid & use_b;

  pipe_addsub #(.WIDTH(16), .STAGES(4)) u_dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .sub(sub), .carryin(carryin), .X(X), .Y(Y),
    .out_valid(out_valid), .out_ready(out_ready), .S(S),
    .carryout(carryout), .overflow(overflow)
  );

  pipe_addsub #(.WIDTH(16), .STAGES(1)) u_s1 (
    .clock(clock), .reset(reset), .in_valid(b_in_valid), .in_ready(s1_in_ready),
    .sub(sub), .carryin(carryin), .X(X), .Y(Y),
    .out_valid(s1_out_valid), .out_ready(out_ready), .S(s1_S),
    .carryout(s1_carryout), .overflow(s1_overflow)
  );

  pipe_addsub #(.WIDTH(16), .STAGES(16)) u_s16 (
    .clock(clock), .reset(reset), .in_valid(b_in_valid), .in_ready(s16_in_ready),
    .sub(sub), .carryin(carryin), .X(X), .Y(Y),
    .out_valid(s16_out_valid), .out_ready(out_ready), .S(s16_S),
    .carryout(s16_carryout), .overflow(s16_overflow)
  );

  // Reference: wide addition, overflow from the operand/result sign rule.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic s, input logic ci);
    logic [15:0] ye;
    logic        c0;
    logic [16:0] t;
    logic        ov;
    ye = s ? ~y : y;
    c0 = s ? 1'b1 : ci;
    t  = {1'b0, x} + {1'b0, ye} + {16'd0, c0};
    ov = (x[15] == ye[15]) && (t[15] != x[15]);
    return {ov, t[16], t[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  // One clock: observe at the falling edge, update scoreboards, return after the rising edge.
  task automatic step();
    logic [17:0] o [3];
    logic        ovl [3];
    logic        ir [3];
    logic        iv [3];
    logic [17:0] e;
    @(negedge clock);
    cyc++;
    o[0] = {overflow, carryout, S};
    o[1] = {s1_overflow, s1_carryout, s1_S};
    o[2] = {s16_overflow, s16_carryout, s16_S};
    ovl[0] = out_valid; ovl[1] = s1_out_valid; ovl[2] = s16_out_valid;
    ir[0] = in_ready;   ir[1] = s1_in_ready;   ir[2] = s16_in_ready;
    iv[0] = in_valid;   iv[1] = b_in_valid;    iv[2] = b_in_valid;
    accepted0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("in_ready_inst%0d", i), {31'd0, ir[i]},
            {31'd0, (out_ready || (q[i].size() < stg[i]))});
      if (prev_stall[i]) check($sformatf("stall_hold_inst%0d", i), {14'd0, o[i]}, {14'd0, held[i]});
      if (ovl[i] && out_ready) begin
        if (q[i].size() == 0) begin
          check($sformatf("spurious_out_inst%0d", i), {31'd0, ovl[i]}, 32'd0);
        end else begin
          e = q[i].pop_front();
          check($sformatf("result_inst%0d", i), {14'd0, o[i]}, {14'd0, e});
          if (i == 0) pop_cyc0 = cyc;
        end
      end
      prev_stall[i] = ovl[i] && !out_ready;
      held[i] = o[i];
      if (iv[i] && ir[i]) begin
        q[i].push_back(cur_exp);
        if (i == 0) begin
          accepted0 = 1'b1;
          acc_cyc0 = cyc;
        end
      end
    end
    if (ir[0] === 1'b0) full_seen++;
    @(posedge clock);
    #1;
    if (tmode) begin
      tpat++;
      out_ready = ((tpat % 3) == 0);
    end
  endtask

  // Present one op and hold it until the 4-stage instance accepts it.
  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic s,
                      input logic ci, input logic [17:0] e);
    X = x; Y = y; sub = s; carryin = ci; cur_exp = e; in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      step();
      if (accepted0) break;
    end
    check("accept", {31'd0, accepted0}, 32'd1);
  endtask

  task automatic send_rand();
    logic [31:0] r;
    logic [15:0] x, y;
    logic        s, ci;
    r = $urandom; x = r[15:0]; y = r[31:16];
    r = $urandom; s = r[0]; ci = r[1];
    send(x, y, s, ci, model(x, y, s, ci));
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if ((q[0].size() + q[1].size() + q[2].size()) == 0) break;
      step();
    end
    check("drain_empty", q[0].size() + q[1].size() + q[2].size(), 32'd0);
  endtask

  initial begin
    stg[0] = 4; stg[1] = 1; stg[2] = 16;
    for (int i = 0; i < 3; i++) begin
      prev_stall[i] = 1'b0;
      held[i] = 18'd0;
    end
    in_valid = 1'b0; sub = 1'b0; carryin = 1'b0; out_ready = 1'b1; use_b = 1'b0;
    X = 16'd0; Y = 16'd0; cur_exp = 18'd0; tmode = 1'b0; tpat = 0; full_seen = 0;
    pop_cyc0 = 0; acc_cyc0 = 0; accepted0 = 1'b0;

    // Reset state
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_S", {16'd0, S}, 32'd0);
    check("rst_carryout", {31'd0, carryout}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("in_ready_after_release", {31'd0, in_ready}, 32'd1);
    @(posedge clock);
    #1;

    // 1: basic add and latency
    send(16'h1234, 16'h4321, 1'b0, 1'b0, {1'b0, 1'b0, 16'h5555});
    drain();
    check("latency", pop_cyc0 - acc_cyc0, 32'd4);

    // 2: carry across all chunks, then signed overflow
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
    send(16'h7FFF, 16'h0000, 1'b0, 1'b1, {1'b1, 1'b0, 16'h8000});
    drain();

    // 3: subtract, carryin ignored; then overflow on subtract
    send(16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    send(16'h8000, 16'h0001, 1'b1, 1'b0, {1'b1, 1'b1, 16'h7FFF});
    drain();

    // 4: 16 back-to-back random ops into all three depths
    use_b = 1'b1;
    c_start = cyc;
    for (int n = 0; n < 16; n++) send_rand();
    check("back_to_back_cycles", cyc - c_start, 32'd16);
    in_valid = 1'b0;
    use_b = 1'b0;
    drain();

    // 5: backpressure with out_ready pattern 1,0,0,...
    full_seen = 0;
    tpat = 0;
    tmode = 1'b1;
    out_ready = 1'b1;
    for (int n = 0; n < 8; n++) send_rand();
    tmode = 1'b0;
    out_ready = 1'b1;
    drain();
    check("pipe_filled", {31'd0, (full_seen > 0)}, 32'd1);

    // 6: reset with three ops in flight
    send(16'h1111, 16'h0001, 1'b0, 1'b0, model(16'h1111, 16'h0001, 1'b0, 1'b0));
    send(16'h2222, 16'h0002, 1'b0, 1'b0, model(16'h2222, 16'h0002, 1'b0, 1'b0));
    send(16'h3333, 16'h0003, 1'b0, 1'b0, model(16'h3333, 16'h0003, 1'b0, 1'b0));
    in_valid = 1'b0;
    step();
    check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_S", {16'd0, S}, 32'd0);
    check("mid_rst_carryout", {31'd0, carryout}, 32'd0);
    check("mid_rst_overflow", {31'd0, overflow}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      q[i].delete();
      prev_stall[i] = 1'b0;
    end
    @(posedge clock);
    #1;
    check("rst_hold_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_hold_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("in_ready_after_release2", {31'd0, in_ready}, 32'd1);
    @(posedge clock);
    #1;
    for (int n = 0; n < 6; n++) step();
    send(16'h0001, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0002});
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
